// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the x4 PLL, clocked by the free-running reference clock.
// Define PLL_LOCK_SEQ_LOSS_CNT_EN to add the saturating LOSS_CNT output.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       CLKI,
    input  logic       RST,
    input  logic       LOCK_IN,
    input  logic       RELOCK_REQ,
    output logic       PLL_RST,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic       FAIL,
    output logic [3:0] RETRY_CNT
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] LOSS_CNT
`endif
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetAssert,
        StWaitLock,
        StStable,
        StReady,
        StFail
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;

    always_ff @(posedge CLKI) begin
        if (RST) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCK_IN;
            lock_s    <= lock_meta;
        end
    end

    // Decoded from flops only, so the pulse lines up with the first cycle lock_s reads low.
    assign LOCK_LOST = (state == StReady) && !lock_s;

    always_ff @(posedge CLKI) begin
        if (RST) begin
            state     <= StResetAssert;
            cnt       <= '0;
            PLL_RST   <= 1'b1;
            READY     <= 1'b0;
            FAIL      <= 1'b0;
            RETRY_CNT <= 4'd0;
        end else begin
            unique case (state)
                StResetAssert: begin
                    if (cnt == RST_LAST) begin
                        state   <= StWaitLock;
                        cnt     <= '0;
                        PLL_RST <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StWaitLock: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s) begin
                        state <= StStable;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        PLL_RST <= 1'b1;
                        if (RETRY_CNT == RETRY_LIMIT) begin
                            state <= StFail;
                            FAIL  <= 1'b1;
                        end else begin
                            state     <= StResetAssert;
                            RETRY_CNT <= RETRY_CNT + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StStable: begin
                    if (!lock_s) begin
                        state <= StWaitLock;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= StReady;
                        cnt   <= '0;
                        READY <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StReady: begin
                    if (!lock_s || RELOCK_REQ) begin
                        state     <= StResetAssert;
                        cnt       <= '0;
                        READY     <= 1'b0;
                        PLL_RST   <= 1'b1;
                        RETRY_CNT <= 4'd0;
                    end
                end
                StFail: begin
                    if (RELOCK_REQ) begin
                        state     <= StResetAssert;
                        cnt       <= '0;
                        FAIL      <= 1'b0;
                        RETRY_CNT <= 4'd0;
                    end
                end
                default: begin
                    state   <= StResetAssert;
                    cnt     <= '0;
                    PLL_RST <= 1'b1;
                    READY   <= 1'b0;
                    FAIL    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    always_ff @(posedge CLKI) begin
        if (RST) begin
            LOSS_CNT <= 8'd0;
        end else if (LOCK_LOST && (LOSS_CNT != 8'hff)) begin
            LOSS_CNT <= LOSS_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controller for the x4 PLL.
- Drives the PLL reset and qualifies its asynchronous lock output.
- Runs a bounded retry loop when the PLL fails to lock, and presents one registered READY to downstream logic that consumes the CLKOP/CLKOS domains.
- Runs on the free-running PLL reference clock, so it stays alive while the PLL is held in reset.

Parameters:
- RST_CYCLES, 16: cycles PLL_RST is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before an attempt is declared failed (>=1).
- STABLE_CYCLES, 256: consecutive synchronised-lock-high cycles required before READY (>=1).
- MAX_RETRIES, 3: extra attempts after the first before FAIL (0..15).

Ports:
- CLKI in 1: reference clock; the only clock.
- RST in 1: synchronous, active-high reset.
- LOCK_IN in 1: PLL LOCK, asynchronous to CLKI.
- RELOCK_REQ in 1: single-cycle request to restart the sequence from READY or FAIL.
- PLL_RST out 1: reset to the PLL, registered.
- READY out 1: PLL locked and stable, registered.
- LOCK_LOST out 1: one-cycle pulse when lock drops while READY.
- FAIL out 1: retries exhausted, sticky until RELOCK_REQ or RST.
- RETRY_CNT out 4: attempts failed in the current episode.

Behaviour:
- LOCK_IN passes through a 2-flop synchroniser (flops reset to 0); lock_s is the second flop. All decisions use lock_s.
- One counter cnt, width $clog2 of the max of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1. It is cleared on every state entry.
- RST values: state=RESET_ASSERT, cnt=0, PLL_RST=1, READY=0, LOCK_LOST=0, FAIL=0, RETRY_CNT=0, sync flops=0. RST wins over all other inputs in any state, including mid-attempt.
- RESET_ASSERT: PLL_RST=1. When cnt==RST_CYCLES-1 go to WAIT_LOCK. PLL_RST is therefore high for exactly RST_CYCLES cycles after reset release.
- WAIT_LOCK: PLL_RST=0.
  - If lock_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1: if RETRY_CNT==MAX_RETRIES, go to FAIL; else RETRY_CNT+1 and go to RESET_ASSERT.
  - If lock_s=1 and timeout occur in the same cycle, lock wins.
- STABLE: PLL_RST=0.
  - If lock_s=0, go to WAIT_LOCK with a fresh timeout; RETRY_CNT is unchanged.
  - If lock_s=1 and cnt==STABLE_CYCLES-1, go to READY.
- READY: PLL_RST=0, READY=1 (registered, high from the first cycle in READY).
  - If lock_s=0: LOCK_LOST=1 for that one cycle, READY=0 next cycle, RETRY_CNT=0, go to RESET_ASSERT.
  - If RELOCK_REQ=1 (and lock_s=1): RETRY_CNT=0, go to RESET_ASSERT, no LOCK_LOST.
  - If both occur in the same cycle, LOCK_LOST pulses and the state goes to RESET_ASSERT.
- FAIL: PLL_RST=1, FAIL=1, READY=0. RELOCK_REQ=1 clears FAIL, clears RETRY_CNT and goes to RESET_ASSERT.
- RELOCK_REQ is ignored in RESET_ASSERT, WAIT_LOCK and STABLE.
- LOCK_LOST is never asserted outside the READY state.
- Latency:
  - From a LOCK_IN rise that then holds, while in WAIT_LOCK, READY rises on the (STABLE_CYCLES+3)th CLKI edge.
  - A lock drop during READY (LOCK_IN falls) produces LOCK_LOST on the 2nd edge and READY low on the 3rd edge.
- Total attempts before FAIL = MAX_RETRIES+1.
- RETRY_CNT saturates by construction at MAX_RETRIES.

Optional Feature:
- Macro: PLL_LOCK_SEQ_LOSS_CNT_EN.
- When defined, adds output LOSS_CNT, 8 bits.
  - Increments on every LOCK_LOST pulse and saturates at 255.
  - Cleared only by RST; RELOCK_REQ does not clear it.
- When undefined, the port and its counter are absent and all other behaviour is identical.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: release RST with LOCK_IN=0, raise LOCK_IN 5 cycles after PLL_RST falls, hold it high -> PLL_RST high exactly 4 cycles; READY rises 11 edges after LOCK_IN; FAIL=0; RETRY_CNT=0.
- Glitchy lock: LOCK_IN high 5 cycles, low 1, then high -> READY delayed; rises 11 edges after the final rise; RETRY_CNT=0.
- No lock: LOCK_IN held 0 ->
  - 3 PLL_RST pulses of 4 cycles each, separated by 16-cycle waits.
  - RETRY_CNT steps 0, 1, 2.
  - FAIL=1 with PLL_RST=1 held.
  - Then RELOCK_REQ pulse -> FAIL=0, RETRY_CNT=0, new 4-cycle PLL_RST.
- Loss in READY: drop LOCK_IN while READY -> LOCK_LOST one cycle on the 2nd edge; READY=0 on the 3rd edge; PLL_RST high 4 cycles; relocks normally. With PLL_LOCK_SEQ_LOSS_CNT_EN, LOSS_CNT=1.
- Simultaneous events:
  - RELOCK_REQ in the same cycle as a lock_s drop in READY -> one LOCK_LOST pulse, single RESET_ASSERT entry.
  - RELOCK_REQ during WAIT_LOCK -> ignored.
- Reset mid-operation: assert RST during STABLE and during FAIL -> next cycle PLL_RST=1, READY=0, FAIL=0, RETRY_CNT=0; sequence restarts with 4 reset cycles.
